sram_sample_fetch: RTL and testbench

- Streams 16-bit audio samples out of the external PSRAM, working alongside the SRAM read port (mem_addr/mem_dout/mem_rdy).
- Generates word addresses from a programmed base and length, and buffers the returned words in a small FIFO.
- Serves one sample per sample_req strobe to the audio output stage.
- Supports one-shot playback or looped playback, and flags underrun when the FIFO cannot supply a requested sample.

---
 rtl/sram_sample_fetch_pkg.sv | 17 +
 rtl/sample_fifo.sv | 77 +++++++
 rtl/sram_sample_fetch.sv | 209 ++++++++++++++++++++
 tb/tb_sram_sample_fetch.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_sample_fetch_pkg.sv
// Shared types and constants for the PSRAM sample fetcher.
package sram_sample_fetch_pkg;

  // Playback state; encodings are fixed so debug probes can decode them.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  localparam int unsigned DefaultAddrW     = 24;
  localparam int unsigned DefaultFifoDepth = 8;

  // Byte distance between consecutive 16-bit samples.
  localparam int unsigned WordStride = 2;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO of 16-bit samples with show-ahead read data and a flush input.
module sample_fifo #(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [15:0]     din_i,
  output logic [15:0]     dout_o,
  output logic [PtrW:0]   count_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(Depth);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
  localparam logic [PtrW:0]   CntOne   = (PtrW + 1)'(1);

  logic [15:0]     mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A full FIFO can still accept a push when the same cycle pops.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state; flush discards everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/sram_sample_fetch.sv
// Streams 16-bit samples from the PSRAM read port into a small FIFO and serves
// them one per request to the audio output stage, one-shot or looped.
module sram_sample_fetch
  import sram_sample_fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth,
  parameter int unsigned ADDR_W     = DefaultAddrW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-2:0] num_words_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [15:0]       mem_dout_i,
  input  logic              mem_rdy_i,
  input  logic              sample_req_i,
  output logic [15:0]       sample_o,
  output logic              sample_valid_o,
  output logic              underrun_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned       CntW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] Stride    = ADDR_W'(WordStride);
  localparam logic [ADDR_W-2:0] WordOne   = (ADDR_W - 1)'(1);
  localparam logic [CntW-1:0]   DepthM1   = CntW'(FIFO_DEPTH - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-2:0] len_q, len_d;
  logic [ADDR_W-2:0] cnt_q, cnt_d;
  logic              loop_q, loop_d;
  logic              all_issued_q, all_issued_d;
  logic              outstanding_q, outstanding_d;
  logic [15:0]       sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              underrun_q, underrun_d;
  logic              done_q, done_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_empty, fifo_full;
  logic [15:0]       fifo_dout;
  logic [CntW-1:0]   fifo_count;
  logic              slot_free;
  logic              start_ok;
  logic [ADDR_W-2:0] cnt_inc;

  sample_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (mem_dout_i),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // A slot is free when count plus the in-flight word is below the depth; this
  // reservation is what keeps the FIFO from ever overflowing.
  assign slot_free = outstanding_q ? (fifo_count < DepthM1) : !fifo_full;
  assign cnt_inc   = cnt_q + WordOne;

  // Fetch FSM: start/stop handling, address issue and FIFO push.
  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    next_addr_d   = next_addr_q;
    base_d        = base_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    loop_d        = loop_q;
    all_issued_d  = all_issued_q;
    outstanding_d = outstanding_q;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    done_d        = 1'b0;
    start_ok      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i && !stop_i) begin
          start_ok = 1'b1;
          if (num_words_i != '0) begin
            state_d      = StFetch;
            base_d       = base_addr_i & AlignMask;
            next_addr_d  = base_addr_i & AlignMask;
            len_d        = num_words_i;
            loop_d       = loop_i;
            cnt_d        = '0;
            all_issued_d = 1'b0;
          end else begin
            // Zero-length song: nothing to play, report completion at once.
            done_d = 1'b1;
          end
        end
      end
      StFetch: begin
        if (stop_i) begin
          // Pending word is dropped: it will never be pushed.
          state_d       = StIdle;
          fifo_flush    = 1'b1;
          outstanding_d = 1'b0;
        end else if (mem_rdy_i) begin
          fifo_push = outstanding_q;
          if (slot_free && !all_issued_q) begin
            mem_addr_d    = next_addr_q;
            outstanding_d = 1'b1;
            cnt_d         = cnt_inc;
            next_addr_d   = next_addr_q + Stride;
            if (cnt_inc == len_q) begin
              if (loop_q) begin
                next_addr_d = base_q;
                cnt_d       = '0;
              end else begin
                all_issued_d = 1'b1;
              end
            end
          end else begin
            outstanding_d = 1'b0;
          end
          // The last word of a one-shot song lands this cycle.
          if (outstanding_q && all_issued_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (stop_i) begin
          state_d       = StIdle;
          fifo_flush    = 1'b1;
          outstanding_d = 1'b0;
        end else if (fifo_empty) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output side: pop on request, sticky underrun on request against empty.
  always_comb begin
    fifo_pop       = sample_req_i && !fifo_empty;
    sample_d       = fifo_pop ? fifo_dout : sample_q;
    sample_valid_d = fifo_pop;
    underrun_d     = underrun_q;
    if (start_ok) begin
      underrun_d = 1'b0;
    end
    // A starving request in the start cycle still counts.
    if (sample_req_i && fifo_empty) begin
      underrun_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      mem_addr_q     <= '0;
      next_addr_q    <= '0;
      base_q         <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      loop_q         <= 1'b0;
      all_issued_q   <= 1'b0;
      outstanding_q  <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_addr_q     <= mem_addr_d;
      next_addr_q    <= next_addr_d;
      base_q         <= base_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      loop_q         <= loop_d;
      all_issued_q   <= all_issued_d;
      outstanding_q  <= outstanding_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
      done_q         <= done_d;
    end
  end

  assign mem_addr_o     = mem_addr_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign underrun_o     = underrun_q;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = done_q;

endmodule

// File: tb/tb_sram_sample_fetch.sv
// Bench for sram_sample_fetch: scenario tasks plus a randomized run against a
// transaction-level playback model.
module tb_sram_sample_fetch;

  localparam int unsigned Depth = 8;
  localparam int unsigned AW    = 24;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, loop_en, mem_rdy, req;
  logic [AW-1:0] base, mem_addr;
  logic [AW-2:0] num;
  logic [15:0]   mem_dout, sample;
  logic          valid, under, busy, done;

  int n_total = 0;
  int n_pass  = 0;
  int rdy_ph  = 0;

  // Model state: what the playback should look like after each edge.
  bit            m_busy, m_drain, m_loop, m_valid, m_under, m_done;
  int            m_out;
  int unsigned   m_len, m_issued;
  logic [AW-1:0] m_addr, m_base;
  logic [15:0]   m_sample;
  logic [15:0]   m_q[$];

  always #5 clk = ~clk;

  // SRAM model: the word presented is the current address / 2.
  assign mem_dout = mem_addr[16:1];

  sram_sample_fetch #(
    .FIFO_DEPTH (Depth),
    .ADDR_W     (AW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .stop_i         (stop),
    .loop_i         (loop_en),
    .base_addr_i    (base),
    .num_words_i    (num),
    .mem_addr_o     (mem_addr),
    .mem_dout_i     (mem_dout),
    .mem_rdy_i      (mem_rdy),
    .sample_req_i   (req),
    .sample_o       (sample),
    .sample_valid_o (valid),
    .underrun_o     (under),
    .busy_o         (busy),
    .done_o         (done)
  );

  task automatic model_step();
    int          size0;
    bit          pop, accept, got;
    int unsigned issued0;
    logic [15:0] word;
    if (!rst_n) begin
      m_busy = 0; m_drain = 0; m_out = 0; m_addr = '0; m_sample = '0;
      m_valid = 0; m_under = 0; m_done = 0; m_q.delete();
      return;
    end
    size0   = m_q.size();
    pop     = req && size0 != 0;
    accept  = start && !stop && !m_busy;
    m_valid = pop;
    m_done  = 0;
    if (pop) m_sample = m_q.pop_front();
    m_under = (m_under && !accept) || (req && size0 == 0);
    if (accept) begin
      if (num != '0) begin
        m_busy = 1; m_drain = 0; m_issued = 0; m_len = num; m_loop = loop_en;
        m_base = {base[AW-1:1], 1'b0};
      end else begin
        m_done = 1;
      end
    end else if (m_busy && stop) begin
      m_busy = 0; m_drain = 0; m_out = 0; m_q.delete();
    end else if (m_busy && m_drain) begin
      if (size0 == 0) begin
        m_busy = 0; m_drain = 0; m_done = 1;
      end
    end else if (m_busy && mem_rdy) begin
      got     = (m_out != 0);
      word    = m_addr[16:1];
      issued0 = m_issued;
      if ((m_loop || m_issued < m_len) && (int'(Depth) - size0 - m_out) > 0) begin
        m_addr = m_base + AW'(2 * (m_issued % m_len));
        m_issued++;
        m_out = 1;
      end else begin
        m_out = 0;
      end
      if (got) begin
        m_q.push_back(word);
        if (!m_loop && issued0 == m_len) m_drain = 1;
      end
    end
  endtask

  // One clock: DUT and model both see the same inputs at the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    rdy_ph  = (rdy_ph + 1) % 3;
    mem_rdy = (rdy_ph == 2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req = (i == 0);
      tick();
      n_total++; if (mem_addr !== '0) $display("FAIL reset_addr: got %h want 0", mem_addr); else n_pass++;
      n_total++; if (sample !== '0) $display("FAIL reset_sample: got %h want 0", sample); else n_pass++;
      n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
      n_total++; if (under !== 1'b0) $display("FAIL reset_underrun: got %b want 0", under); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    end
    req = 1'b0; rst_n = 1'b1;
    tick();
    n_total++; if (under !== 1'b0) $display("FAIL post_reset_underrun: got %b want 0", under); else n_pass++;
    req = 1'b1;
    tick();
    req = 1'b0;
    n_total++; if (under !== 1'b1) $display("FAIL idle_underrun: got %b want 1", under); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL idle_req_valid: got %b want 0", valid); else n_pass++;
  endtask

  task automatic test_one_shot();
    logic [AW-1:0] prev;
    logic [AW-1:0] addrs[$];
    int            done_cnt = 0;
    base = 24'h000100; num = 23'd5; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL one_shot_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (under !== 1'b0) $display("FAIL one_shot_underrun_clear: got %b want 0", under); else n_pass++;
    prev = mem_addr;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (mem_addr !== prev) addrs.push_back(mem_addr);
      prev = mem_addr;
    end
    n_total++; if (addrs.size() != 5) $display("FAIL one_shot_issue_count: got %0d want 5", addrs.size()); else n_pass++;
    for (int i = 0; i < addrs.size() && i < 5; i++) begin
      n_total++;
      if (addrs[i] !== 24'h100 + AW'(2 * i)) $display("FAIL one_shot_addr%0d: got %h want %h", i, addrs[i], 24'h100 + AW'(2 * i));
      else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      req = 1'b1;
      tick();
      req = 1'b0;
      n_total++; if (valid !== 1'b1) $display("FAIL one_shot_valid%0d: got %b want 1", i, valid); else n_pass++;
      n_total++; if (sample !== 16'h0080 + 16'(i)) $display("FAIL one_shot_sample%0d: got %h want %h", i, sample, 16'h0080 + 16'(i)); else n_pass++;
      if (done === 1'b1) done_cnt++;
      tick();
      if (done === 1'b1) done_cnt++;
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    n_total++; if (done_cnt != 1) $display("FAIL one_shot_done_pulses: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL one_shot_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] prev;
    int            issues = 0;
    bit            moved  = 0;
    base = 24'h000102; num = 23'd20; loop_en = 1'b0; start = 1'b1;
    prev = mem_addr;
    tick();
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (mem_addr !== prev) issues++;
      prev = mem_addr;
    end
    n_total++; if (issues != 8) $display("FAIL bp_issue_count: got %0d want 8", issues); else n_pass++;
    n_total++; if (mem_addr !== 24'h110) $display("FAIL bp_hold_addr: got %h want 000110", mem_addr); else n_pass++;
    req = 1'b1;
    tick();
    req = 1'b0;
    n_total++; if (sample !== 16'h0081) $display("FAIL bp_first_sample: got %h want 0081", sample); else n_pass++;
    for (int c = 0; c < 6 && !moved; c++) begin
      tick();
      moved = (mem_addr !== 24'h110);
    end
    n_total++; if (mem_addr !== 24'h112) $display("FAIL bp_resume_addr: got %h want 000112", mem_addr); else n_pass++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL bp_stop_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_loop_wrap();
    int busy_drops = 0;
    int dones      = 0;
    base = 24'h000200; num = 23'd3; loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (busy !== 1'b1) busy_drops++;
      if (done === 1'b1) dones++;
    end
    for (int k = 0; k < 15; k++) begin
      req = 1'b1;
      tick();
      req = 1'b0;
      n_total++;
      if (valid !== 1'b1 || sample !== 16'h0100 + 16'(k % 3))
        $display("FAIL loop_sample%0d: got %h/%b want %h/1", k, sample, valid, 16'h0100 + 16'(k % 3));
      else n_pass++;
      for (int c = 0; c < 5; c++) begin
        tick();
        if (busy !== 1'b1) busy_drops++;
        if (done === 1'b1) dones++;
      end
    end
    n_total++; if (busy_drops != 0) $display("FAIL loop_busy_drops: got %0d want 0", busy_drops); else n_pass++;
    n_total++; if (dones != 0) $display("FAIL loop_done_pulses: got %0d want 0", dones); else n_pass++;
    n_total++; if (under !== 1'b0) $display("FAIL loop_underrun: got %b want 0", under); else n_pass++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_underrun();
    logic [AW-1:0] b;
    int            n, k = 0, dones = 0;
    b = AW'($urandom);
    n = $urandom_range(4, 10);
    base = b; num = (AW - 1)'(n); loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    n_total++; if (under !== 1'b1) $display("FAIL ur_flag: got %b want 1", under); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL ur_valid: got %b want 0", valid); else n_pass++;
    for (int c = 0; c < 300 && dones == 0; c++) begin
      req = ($urandom_range(0, 2) == 0);
      tick();
      if (valid === 1'b1) begin
        n_total++;
        if (sample !== 16'(b[16:1] + 16'(k))) $display("FAIL ur_order%0d: got %h want %h", k, sample, 16'(b[16:1] + 16'(k)));
        else n_pass++;
        k++;
      end
      if (done === 1'b1) dones++;
    end
    req = 1'b0;
    n_total++; if (k != n) $display("FAIL ur_sample_count: got %0d want %0d", k, n); else n_pass++;
    n_total++; if (dones != 1) $display("FAIL ur_done: got %0d want 1", dones); else n_pass++;
    n_total++; if (under !== 1'b1) $display("FAIL ur_sticky: got %b want 1", under); else n_pass++;
    base = 24'h0; num = 23'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (under !== 1'b0) $display("FAIL ur_clear_on_start: got %b want 0", under); else n_pass++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_stop();
    bit ready = 0;
    int dones = 0;
    base = 24'h000300; num = 23'd20; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && !ready; c++) begin
      tick();
      ready = (m_q.size() == 3 && m_out == 1);
    end
    n_total++; if (!ready) $display("FAIL stop_setup: got timeout want 3 buffered"); else n_pass++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL stop_busy: got %b want 0", busy); else n_pass++;
    if (done === 1'b1) dones++;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_total++; if (dones != 0) $display("FAIL stop_done: got %0d want 0", dones); else n_pass++;
    req = 1'b1;
    tick();
    req = 1'b0;
    n_total++; if (under !== 1'b1) $display("FAIL stop_flushed: got %b want 1", under); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL stop_flushed_valid: got %b want 0", valid); else n_pass++;
    base = 24'h000400; num = 23'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    for (int i = 0; i < 2; i++) begin
      req = 1'b1;
      tick();
      req = 1'b0;
      n_total++;
      if (valid !== 1'b1 || sample !== 16'h0200 + 16'(i))
        $display("FAIL restart_sample%0d: got %h/%b want %h/1", i, sample, valid, 16'h0200 + 16'(i));
      else n_pass++;
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_total++; if (dones != 1) $display("FAIL restart_done: got %0d want 1", dones); else n_pass++;
  endtask

  task automatic test_random();
    int dens;
    for (int ep = 0; ep < 8; ep++) begin
      base = AW'($urandom); num = (AW - 1)'($urandom_range(0, 12));
      loop_en = ($urandom_range(0, 1) == 1);
      dens = $urandom_range(0, 6);
      for (int c = 0; c < 90; c++) begin
        req   = ($urandom_range(0, 9) < dens);
        stop  = ($urandom_range(0, 99) == 0);
        start = (c == 0) || ($urandom_range(0, 29) == 0);
        tick();
        n_total++; if (mem_addr !== m_addr) $display("FAIL rnd_addr ep%0d c%0d: got %h want %h", ep, c, mem_addr, m_addr); else n_pass++;
        n_total++; if (valid !== m_valid) $display("FAIL rnd_valid ep%0d c%0d: got %b want %b", ep, c, valid, m_valid); else n_pass++;
        n_total++; if (sample !== m_sample) $display("FAIL rnd_sample ep%0d c%0d: got %h want %h", ep, c, sample, m_sample); else n_pass++;
        n_total++; if (under !== m_under) $display("FAIL rnd_underrun ep%0d c%0d: got %b want %b", ep, c, under, m_under); else n_pass++;
        n_total++; if (busy !== m_busy) $display("FAIL rnd_busy ep%0d c%0d: got %b want %b", ep, c, busy, m_busy); else n_pass++;
        n_total++; if (done !== m_done) $display("FAIL rnd_done ep%0d c%0d: got %b want %b", ep, c, done, m_done); else n_pass++;
      end
      req = 1'b0; start = 1'b0; stop = 1'b1;
      tick();
      stop = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    base = '0; num = '0; req = 1'b0; mem_rdy = 1'b0;
    test_reset();
    test_one_shot();
    test_backpressure();
    test_loop_wrap();
    test_underrun();
    test_stop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
